watch_display: RTL

- Consumer end of the watch time bus. Takes the six 4-bit BCD digits (HH:MM:SS) produced by the watch block.
- Drives a 6-digit multiplexed, common-anode 7-segment display: one digit active at a time, round-robin.
- Snapshots the time once per scan frame so a digit never updates part-way through a frame (no tearing).

---
 rtl/watch_display.sv | 110 +++++++++++
 1 files changed

// File: rtl/watch_display.sv
// Six-digit multiplexed common-anode 7-segment driver for the HH:MM:SS BCD time bus.
// Time is snapshotted into shadow registers once per scan frame so no digit tears mid-frame.
module watch_display #(
  parameter int unsigned PRESCALE      = 4,
  parameter bit          LEADING_BLANK = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [3:0] sec_lsb,
  input  logic [3:0] sec_msb,
  input  logic [3:0] min_lsb,
  input  logic [3:0] min_msb,
  input  logic [3:0] hr_lsb,
  input  logic [3:0] hr_msb,
  output logic [6:0] seg_n,
  output logic       dp_n,
  output logic [5:0] an_n,
  output logic       frame_done
);

  localparam logic [15:0] LAST = 16'(PRESCALE - 1);

  logic [15:0] pcnt;
  logic [2:0]  idx;
  logic [3:0]  shadow [6];
  logic        scan_on;
  logic [3:0]  digit;

  function automatic logic [6:0] seg_decode(input logic [3:0] bcd);
    case (bcd)
      4'd0:    seg_decode = 7'h40;
      4'd1:    seg_decode = 7'h79;
      4'd2:    seg_decode = 7'h24;
      4'd3:    seg_decode = 7'h30;
      4'd4:    seg_decode = 7'h19;
      4'd5:    seg_decode = 7'h12;
      4'd6:    seg_decode = 7'h02;
      4'd7:    seg_decode = 7'h78;
      4'd8:    seg_decode = 7'h00;
      4'd9:    seg_decode = 7'h10;
      default: seg_decode = 7'h3F;
    endcase
  endfunction

  // Scan state: prescaler, digit index, frame snapshot and frame pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt       <= '0;
      idx        <= '0;
      scan_on    <= 1'b0;
      frame_done <= 1'b0;
      for (int k = 0; k < 6; k++) shadow[k] <= '0;
    end else begin
      scan_on    <= enable;
      frame_done <= 1'b0;
      if (!enable) begin
        pcnt      <= '0;
        idx       <= '0;
        shadow[0] <= sec_lsb;
        shadow[1] <= sec_msb;
        shadow[2] <= min_lsb;
        shadow[3] <= min_msb;
        shadow[4] <= hr_lsb;
        shadow[5] <= hr_msb;
      end else if (pcnt != LAST) begin
        pcnt <= pcnt + 16'd1;
      end else begin
        pcnt <= '0;
        if (idx == 3'd5) begin
          idx        <= '0;
          frame_done <= 1'b1;
          shadow[0]  <= sec_lsb;
          shadow[1]  <= sec_msb;
          shadow[2]  <= min_lsb;
          shadow[3]  <= min_msb;
          shadow[4]  <= hr_lsb;
          shadow[5]  <= hr_msb;
        end else begin
          idx <= idx + 3'd1;
        end
      end
    end
  end

  always_comb begin
    case (idx)
      3'd0:    digit = shadow[0];
      3'd1:    digit = shadow[1];
      3'd2:    digit = shadow[2];
      3'd3:    digit = shadow[3];
      3'd4:    digit = shadow[4];
      default: digit = shadow[5];
    endcase
  end

  // Outputs come only from registered state; scan_on lags enable by one clock
  always_comb begin
    an_n  = 6'h3F;
    seg_n = 7'h7F;
    dp_n  = 1'b1;
    if (scan_on) begin
      an_n  = ~(6'b000001 << idx);
      seg_n = seg_decode(digit);
      dp_n  = !((idx == 3'd2) || (idx == 3'd4));
      if (LEADING_BLANK && (idx == 3'd5) && (digit == 4'd0)) seg_n = 7'h7F;
    end
  end

endmodule
